// File: rtl/regfile_arb_pkg.sv
// Shared widths, source encoding and slot record for the register-file write arbiter.
// Widths live here so every file of the arbiter agrees on them.
package regfile_arb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic SRC_ID  = 1'b0;
    localparam logic SRC_ALU = 1'b1;

    typedef struct packed {
        logic              full;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

endpackage

// File: rtl/regfile_arb_slot.sv
// One-entry write buffer with valid/ready intake and a read-address compare.
// A grant and a reload may land on the same edge; the reload wins.
module regfile_arb_slot
    import regfile_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              grant_i,
    input  logic [ADDR_W-1:0] cmp_addr1_i,
    input  logic [ADDR_W-1:0] cmp_addr2_i,
    output logic              ready_o,
    output logic              load_o,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              match_o
);

    slot_t slot_q, slot_d;

    assign ready_o = ~slot_q.full | grant_i;
    assign load_o  = valid_i & ready_o;

    always_comb begin
        slot_d = slot_q;
        if (load_o) begin
            slot_d.full = 1'b1;
            slot_d.addr = addr_i;
            slot_d.data = data_i;
        end else if (grant_i) begin
            slot_d.full = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign full_o  = slot_q.full;
    assign addr_o  = slot_q.addr;
    assign data_o  = slot_q.data;
    assign match_o = slot_q.full &
                     ((slot_q.addr == cmp_addr1_i) |
                      (slot_q.addr == cmp_addr2_i));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and ID writes onto the single register-file write port.
// Define REGFILE_ARB_HAZARD_EN to enable read-after-write hazard reporting.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_addr,
    input  logic [DATA_W-1:0] id_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_value_alu,
    output logic [DATA_W-1:0] write_value_id,
    output logic              write_data_sel,
    output logic              write_enable,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic              hazard,
    output logic              busy
);

    logic              alu_grant, id_grant;
    logic              alu_load, id_load;
    logic              alu_full, id_full;
    logic              alu_match, id_match;
    logic [ADDR_W-1:0] alu_qaddr, id_qaddr;
    logic [DATA_W-1:0] alu_qdata, id_qdata;

    logic              older_q, older_d;
    logic              we_q, we_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] valu_q, valu_d;
    logic [DATA_W-1:0] vid_q, vid_d;

    regfile_arb_slot u_alu_slot (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (alu_valid),
        .addr_i      (alu_addr),
        .data_i      (alu_data),
        .grant_i     (alu_grant),
        .cmp_addr1_i (read_addr1),
        .cmp_addr2_i (read_addr2),
        .ready_o     (alu_ready),
        .load_o      (alu_load),
        .full_o      (alu_full),
        .addr_o      (alu_qaddr),
        .data_o      (alu_qdata),
        .match_o     (alu_match)
    );

    regfile_arb_slot u_id_slot (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (id_valid),
        .addr_i      (id_addr),
        .data_i      (id_data),
        .grant_i     (id_grant),
        .cmp_addr1_i (read_addr1),
        .cmp_addr2_i (read_addr2),
        .ready_o     (id_ready),
        .load_o      (id_load),
        .full_o      (id_full),
        .addr_o      (id_qaddr),
        .data_o      (id_qdata),
        .match_o     (id_match)
    );

    assign alu_grant = alu_full & (~id_full | (older_q == SRC_ALU));
    assign id_grant  = id_full & ~alu_grant;

    // Age follows whichever slot stays full while the other one loads.
    always_comb begin
        older_d = older_q;
        if (alu_load && id_load) begin
            older_d = SRC_ID;
        end else if (alu_load) begin
            older_d = (id_full & ~id_grant) ? SRC_ID : SRC_ALU;
        end else if (id_load) begin
            older_d = (alu_full & ~alu_grant) ? SRC_ALU : SRC_ID;
        end
    end

    always_comb begin
        we_d    = alu_grant | id_grant;
        sel_d   = sel_q;
        waddr_d = waddr_q;
        valu_d  = valu_q;
        vid_d   = vid_q;
        if (alu_grant) begin
            sel_d   = SRC_ALU;
            waddr_d = alu_qaddr;
            valu_d  = alu_qdata;
        end else if (id_grant) begin
            sel_d   = SRC_ID;
            waddr_d = id_qaddr;
            vid_d   = id_qdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            older_q <= SRC_ID;
            we_q    <= 1'b0;
            sel_q   <= SRC_ID;
            waddr_q <= '0;
            valu_q  <= '0;
            vid_q   <= '0;
        end else begin
            older_q <= older_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            waddr_q <= waddr_d;
            valu_q  <= valu_d;
            vid_q   <= vid_d;
        end
    end

    assign write_enable    = we_q;
    assign write_addr      = waddr_q;
    assign write_data_sel  = sel_q;
    assign write_value_alu = valu_q;
    assign write_value_id  = vid_q;
    assign busy            = alu_full | id_full | we_q;

`ifdef REGFILE_ARB_HAZARD_EN
    // The write in flight is not yet visible to combinational reads.
    assign hazard = alu_match | id_match |
                    (we_q & ((waddr_q == read_addr1) |
                             (waddr_q == read_addr2)));
`else
    logic unused_match;
    assign unused_match = alu_match ^ id_match;
    assign hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Vector table for the directed corners, then random traffic against an age-stamp model.
// Register-file contents seen through the write port are compared at the end.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, id_valid;
    logic        alu_ready, id_ready;
    logic [2:0]  alu_addr, id_addr;
    logic [31:0] alu_data, id_data;
    logic [2:0]  write_addr;
    logic [31:0] write_value_alu, write_value_id;
    logic        write_data_sel, write_enable;
    logic [2:0]  read_addr1, read_addr2;
    logic        hazard, busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] dut_rf [8];
    logic [31:0] m_rf   [8];

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_addr         (id_addr),
        .id_data         (id_data),
        .write_addr      (write_addr),
        .write_value_alu (write_value_alu),
        .write_value_id  (write_value_id),
        .write_data_sel  (write_data_sel),
        .write_enable    (write_enable),
        .read_addr1      (read_addr1),
        .read_addr2      (read_addr2),
        .hazard          (hazard),
        .busy            (busy)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [2:0]  aa;
        logic [31:0] ad;
        logic        iv;
        logic [2:0]  ia;
        logic [31:0] idt;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic        ar;
        logic        ir;
        logic        we;
        logic [2:0]  wa;
        logic        sel;
        logic [31:0] va;
        logic [31:0] vi;
        logic        bsy;
        logic        haz;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        bit          full;
        logic [2:0]  a;
        logic [31:0] d;
        int          stamp;
    } mslot_t;

    mslot_t      ms [2];
    bit          m_we;
    logic [2:0]  m_wa;
    bit          m_sel;
    logic [31:0] m_va, m_vi;
    int          m_cyc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ar,
                             input logic ir, input logic we,
                             input logic [2:0] wa, input logic sel,
                             input logic [31:0] va, input logic [31:0] vi,
                             input logic bsy, input logic haz);
        logic eh;
`ifdef REGFILE_ARB_HAZARD_EN
        eh = haz;
`else
        eh = 1'b0;
`endif
        chk({tag, ".alu_ready"}, alu_ready, ar);
        chk({tag, ".id_ready"}, id_ready, ir);
        chk({tag, ".we"}, write_enable, we);
        chk({tag, ".waddr"}, write_addr, wa);
        chk({tag, ".sel"}, write_data_sel, sel);
        chk({tag, ".val_alu"}, write_value_alu, va);
        chk({tag, ".val_id"}, write_value_id, vi);
        chk({tag, ".busy"}, busy, bsy);
        chk({tag, ".hazard"}, hazard, eh);
    endtask

    task automatic drive(input logic r, input logic av, input logic [2:0] aa,
                         input logic [31:0] ad, input logic iv,
                         input logic [2:0] ia, input logic [31:0] idt,
                         input logic [2:0] r1, input logic [2:0] r2);
        rst        = r;
        alu_valid  = av;
        alu_addr   = aa;
        alu_data   = ad;
        id_valid   = iv;
        id_addr    = ia;
        id_data    = idt;
        read_addr1 = r1;
        read_addr2 = r2;
    endtask

    task automatic dut_commit();
        if (write_enable === 1'b1)
            dut_rf[write_addr] = write_data_sel ? write_value_alu
                                                : write_value_id;
    endtask

    task automatic add(input logic r, input logic av, input logic [2:0] aa,
                       input logic [31:0] ad, input logic iv,
                       input logic [2:0] ia, input logic [31:0] idt,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input logic ar, input logic ir, input logic we,
                       input logic [2:0] wa, input logic sel,
                       input logic [31:0] va, input logic [31:0] vi,
                       input logic bsy, input logic haz);
        vec_t v;
        v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
        v.iv = iv;  v.ia = ia; v.idt = idt;
        v.r1 = r1;  v.r2 = r2;
        v.ar = ar;  v.ir = ir; v.we = we; v.wa = wa; v.sel = sel;
        v.va = va;  v.vi = vi; v.bsy = bsy; v.haz = haz;
        tbl.push_back(v);
    endtask

    function automatic int m_win();
        if (ms[0].full && ms[1].full)
            return (ms[1].stamp < ms[0].stamp) ? 1 : 0;
        if (ms[0].full) return 0;
        if (ms[1].full) return 1;
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 2; s++) ms[s].full = 0;
        m_we = 0; m_wa = 0; m_sel = 0; m_va = 0; m_vi = 0;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] A1 = 32'hA1A1_0001;
    localparam logic [31:0] B1 = 32'hB1B1_0001;
    localparam logic [31:0] B2 = 32'hB2B2_0002;
    localparam logic [31:0] B3 = 32'hB3B3_0003;
    localparam logic [31:0] C1 = 32'hC1C1_0001;
    localparam logic [31:0] D1 = 32'hD1D1_0001;
    localparam logic [31:0] E1 = 32'hE1E1_0001;
    localparam logic [31:0] E2 = 32'hE2E2_0002;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // rst av aa ad  iv ia id  r1 r2 | ar ir we wa sel va vi busy haz
        add(0,0,0,0,  0,0,0,  0,0, 1,1,0,0,0,0,0,0,0);
        add(0,1,3,DB, 0,0,0,  0,0, 1,1,0,0,0,0,0,0,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,0,0,0,0,0,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,1,3,1,DB,0,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,0,3,1,DB,0,0,0);
        add(0,1,5,1,  1,5,2,  0,0, 1,1,0,3,1,DB,0,0,0);
        add(0,0,0,0,  0,0,0,  0,0, 0,1,0,3,1,DB,0,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,1,5,0,DB,2,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,1,5,1,1,2,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,0,5,1,1,2,0,0);
        add(0,1,1,A1, 1,2,B1, 0,0, 1,1,0,5,1,1,2,0,0);
        add(0,0,0,0,  1,4,B2, 0,0, 0,1,0,5,1,1,2,1,0);
        add(0,0,0,0,  1,6,B3, 0,0, 1,0,1,2,0,1,B1,1,0);
        add(0,0,0,0,  1,6,B3, 0,0, 1,1,1,1,1,A1,B1,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,1,4,0,A1,B2,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,1,6,0,A1,B3,1,0);
        add(0,0,0,0,  0,0,0,  0,0, 1,1,0,6,0,A1,B3,0,0);
        add(0,1,2,C1, 0,0,0,  2,0, 1,1,0,6,0,A1,B3,0,0);
        add(0,0,0,0,  0,0,0,  2,0, 1,1,0,6,0,A1,B3,1,1);
        add(0,0,0,0,  0,0,0,  2,0, 1,1,1,2,1,C1,B3,1,1);
        add(0,0,0,0,  0,0,0,  2,0, 1,1,0,2,1,C1,B3,0,0);
        add(0,0,0,0,  1,7,D1, 0,7, 1,1,0,2,1,C1,B3,0,0);
        add(0,0,0,0,  0,0,0,  0,7, 1,1,0,2,1,C1,B3,1,1);
        add(0,0,0,0,  0,0,0,  0,7, 1,1,1,7,0,C1,D1,1,1);
        add(0,0,0,0,  0,0,0,  0,7, 1,1,0,7,0,C1,D1,0,0);
        add(0,1,0,E1, 1,1,E2, 5,5, 1,1,0,7,0,C1,D1,0,0);
        add(1,0,0,0,  0,0,0,  5,5, 0,1,0,7,0,C1,D1,1,0);
        add(0,0,0,0,  0,0,0,  5,5, 1,1,0,0,0,0,0,0,0);
        add(0,0,0,0,  0,0,0,  5,5, 1,1,0,0,0,0,0,0,0);

        for (int r = 0; r < 8; r++) begin
            dut_rf[r] = '0;
            m_rf[r]   = '0;
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad,
                  tbl[i].iv, tbl[i].ia, tbl[i].idt,
                  tbl[i].r1, tbl[i].r2);
            #1;
            check_all($sformatf("tbl%0d", i), tbl[i].ar, tbl[i].ir,
                      tbl[i].we, tbl[i].wa, tbl[i].sel, tbl[i].va,
                      tbl[i].vi, tbl[i].bsy, tbl[i].haz);
            dut_commit();
            @(posedge clk);
            @(negedge clk);
        end
        chk("tbl.r5_final", dut_rf[5], 32'h1);

        // Random traffic against the age-stamp model.
        for (int r = 0; r < 8; r++) begin
            dut_rf[r] = '0;
            m_rf[r]   = '0;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        m_reset();
        m_cyc = 0;

        for (int k = 0; k < 2000; k++) begin
            logic        r, av, iv;
            logic [2:0]  aa, ia, r1, r2;
            logic [31:0] ad, idt;
            int          w;
            logic        ar, ir, hz;
            r   = ($urandom_range(0, 99) == 0);
            av  = $urandom_range(0, 1);
            iv  = $urandom_range(0, 1);
            aa  = 3'($urandom_range(0, 7));
            ia  = 3'($urandom_range(0, 7));
            r1  = 3'($urandom_range(0, 7));
            r2  = 3'($urandom_range(0, 7));
            ad  = $urandom;
            idt = $urandom;
            drive(r, av, aa, ad, iv, ia, idt, r1, r2);
            #1;
            w  = m_win();
            ar = !ms[1].full || (w == 1);
            ir = !ms[0].full || (w == 0);
            hz = (ms[0].full && (ms[0].a == r1 || ms[0].a == r2)) ||
                 (ms[1].full && (ms[1].a == r1 || ms[1].a == r2)) ||
                 (m_we && (m_wa == r1 || m_wa == r2));
            check_all($sformatf("rnd%0d", k), ar, ir, m_we, m_wa, m_sel,
                      m_va, m_vi,
                      ms[0].full || ms[1].full || m_we, hz);
            dut_commit();
            @(posedge clk);
            m_cyc++;
            if (m_we) m_rf[m_wa] = m_sel ? m_va : m_vi;
            if (r) begin
                m_reset();
            end else begin
                m_we = (w >= 0);
                if (w == 1) begin
                    m_wa = ms[1].a; m_sel = 1; m_va = ms[1].d;
                    ms[1].full = 0;
                end else if (w == 0) begin
                    m_wa = ms[0].a; m_sel = 0; m_vi = ms[0].d;
                    ms[0].full = 0;
                end
                if (av && ar) ms[1] = '{1, aa, ad, m_cyc};
                if (iv && ir) ms[0] = '{1, ia, idt, m_cyc};
            end
            @(negedge clk);
        end

        for (int r = 0; r < 8; r++)
            chk($sformatf("rf%0d", r), dut_rf[r], m_rf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
